// File: rtl/pio_input_conditioner.sv
// Eight-channel synchroniser, per-bit debouncer and edge strobe generator feeding the PIO input port.
// Optional sticky edge-capture register with interrupt, enabled by PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN.
module pio_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] edge_capture,
    input  logic             clear_en,
    input  logic [WIDTH-1:0] clear_mask,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A channel accepts a new level on its DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++)
            accept[i] = (sync[i] != clean_q[i]) && (cnt_q[i] == CNT_MAX);
    end

    // NOTE: the counter array is a register bank, not RAM, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == clean_q[i] || accept[i])
                    cnt_q[i] <= '0;
                else
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            clean_q <= clean_q ^ accept;
            rise_q  <= accept & sync;
            fall_q  <= accept & ~sync;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef PIO_INPUT_CONDITIONER_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] capture_q;

    // A strobe arriving in the same cycle as a clear keeps its bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            capture_q <= '0;
        else
            capture_q <= (capture_q & ~({WIDTH{clear_en}} & clear_mask)) | rise_q | fall_q;
    end

    assign edge_capture = capture_q;
    assign irq          = |capture_q;
`else
    logic unused_clear;

    assign unused_clear = &{1'b0, clear_en, clear_mask};
    assign edge_capture = '0;
    assign irq          = 1'b0;
`endif

endmodule
